// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: merges primary and FIFO-buffered secondary results onto one RF write port, with a pending scoreboard; WB_BYPASS_EN lets a secondary result skip an empty FIFO
module rf_writeback_queue #(
   parameter int DEPTH = 4,
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pri_wr,
   input  logic [AW-1:0]            pri_addr,
   input  logic [DW-1:0]            pri_data,
   input  logic                     sec_valid,
   output logic                     sec_ready,
   input  logic [AW-1:0]            sec_addr,
   input  logic [DW-1:0]            sec_data,
   input  logic                     mark_valid,
   input  logic [AW-1:0]            mark_addr,
   input  logic [AW-1:0]            chk_addr1,
   input  logic [AW-1:0]            chk_addr2,
   output logic                     busy1,
   output logic                     busy2,
   output logic                     wr,
   output logic [AW-1:0]            addr3,
   output logic [DW-1:0]            data3,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = DEPTH[CW-1:0];
   logic [AW-1:0] mem_a [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [PW-1:0] wp, rp;
   logic [(1<<AW)-1:0] pending;
   logic out_sec, pri_sel, acc, push, pop, byp;
   assign sec_ready = !reset && count != FULL;
   assign busy1 = chk_addr1 != '0 && pending[chk_addr1];
   assign busy2 = chk_addr2 != '0 && pending[chk_addr2];
   always_comb begin
      pri_sel = pri_wr && pri_addr != '0;
      acc = sec_valid && sec_ready && sec_addr != '0;
      pop = !pri_sel && count != '0;
`ifdef WB_BYPASS_EN
      byp = !pri_sel && count == '0 && acc;
`else
      byp = 1'b0;
`endif
      push = acc && !byp;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr <= 1'b0;
         out_sec <= 1'b0;
         addr3 <= '0;
         data3 <= '0;
         count <= '0;
         wp <= '0;
         rp <= '0;
         pending <= '0;
      end else begin
         wr <= pri_sel || pop || byp;
         out_sec <= !pri_sel && (pop || byp);
         addr3 <= pri_sel ? pri_addr : pop ? mem_a[rp] : sec_addr;
         data3 <= pri_sel ? pri_data : pop ? mem_d[rp] : sec_data;
         wp <= wp + PW'(push);
         rp <= rp + PW'(pop);
         count <= count + CW'(push) - CW'(pop);
         // a new mark on the register being committed must survive, so it is applied last
         if (wr && out_sec) pending[addr3] <= 1'b0;
         if (mark_valid && mark_addr != '0) pending[mark_addr] <= 1'b1;
      end
   always_ff @(posedge clk)
      if (push) begin
         mem_a[wp] <= sec_addr;
         mem_d[wp] <= sec_data;
      end
endmodule

// File: tb/tb_rf_writeback_queue.sv
// tb_rf_writeback_queue: directed vectors for rf_writeback_queue
module tb_rf_writeback_queue;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int DEPTH = 4;
   logic clk = 1'b0, reset = 1'b1;
   logic pri_wr = 1'b0, sec_valid = 1'b0, mark_valid = 1'b0;
   logic [AW-1:0] pri_addr = '0, sec_addr = '0, mark_addr = '0, chk_addr1 = '0, chk_addr2 = '0;
   logic [DW-1:0] pri_data = '0, sec_data = '0;
   logic sec_ready, busy1, busy2, wr;
   logic [AW-1:0] addr3;
   logic [DW-1:0] data3;
   logic [$clog2(DEPTH):0] count;
   int vectors = 0, miscompares = 0;
   rf_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset), .pri_wr(pri_wr), .pri_addr(pri_addr), .pri_data(pri_data),
      .sec_valid(sec_valid), .sec_ready(sec_ready), .sec_addr(sec_addr), .sec_data(sec_data),
      .mark_valid(mark_valid), .mark_addr(mark_addr), .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
      .busy1(busy1), .busy2(busy2), .wr(wr), .addr3(addr3), .data3(data3), .count(count)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic wait_wr(input string tag);
      for (int i = 0; i < 4 && wr !== 1'b1; i++) step();
      check(tag, 32'(wr), 1);
   endtask
   initial begin
      step();
      step();
      check("rst_wr", 32'(wr), 0);
      check("rst_addr3", 32'(addr3), 0);
      check("rst_data3", data3, 0);
      check("rst_count", 32'(count), 0);
      check("rst_ready", 32'(sec_ready), 0);
      check("rst_busy1", 32'(busy1), 0);
      reset = 1'b0;
      #1;
      check("rel_ready", 32'(sec_ready), 1);
      // primary write and dropped r0 write
      pri_wr = 1'b1; pri_addr = 5; pri_data = 32'h1234;
      step();
      check("pri_wr", 32'(wr), 1);
      check("pri_addr3", 32'(addr3), 5);
      check("pri_data3", data3, 32'h1234);
      pri_wr = 1'b0;
      step();
      check("pri_one_cycle", 32'(wr), 0);
      pri_wr = 1'b1; pri_addr = 0;
      step();
      check("pri_r0_drop", 32'(wr), 0);
      pri_wr = 1'b0;
      // secondary r0 is accepted and discarded
      sec_valid = 1'b1; sec_addr = 0; sec_data = 32'h55;
      step();
      sec_valid = 1'b0;
      check("sec_r0_count", 32'(count), 0);
      check("sec_r0_wr", 32'(wr), 0);
      // scoreboard and secondary latency
      mark_valid = 1'b1; mark_addr = 8; chk_addr1 = 8;
      step();
      mark_valid = 1'b0;
      check("mark_busy", 32'(busy1), 1);
      sec_valid = 1'b1; sec_addr = 8; sec_data = 32'hDEAD;
      step();
      sec_valid = 1'b0;
`ifdef WB_BYPASS_EN
      check("byp_wr", 32'(wr), 1);
      check("byp_count", 32'(count), 0);
      check("byp_addr3", 32'(addr3), 8);
      check("byp_busy_hold", 32'(busy1), 1);
`else
      check("push_wr", 32'(wr), 0);
      check("push_count", 32'(count), 1);
      check("push_busy", 32'(busy1), 1);
      step();
      check("pop_wr", 32'(wr), 1);
      check("pop_addr3", 32'(addr3), 8);
      check("pop_data3", data3, 32'hDEAD);
      check("pop_busy_hold", 32'(busy1), 1);
`endif
      step();
      check("commit_busy", 32'(busy1), 0);
      check("commit_wr", 32'(wr), 0);
      // fill to full behind held primary, then drain in order
      pri_wr = 1'b1; pri_addr = 3; pri_data = 32'h100;
      for (int i = 0; i < 4; i++) begin
         sec_valid = 1'b1; sec_addr = AW'(10 + i); sec_data = 32'hA0 + i;
         step();
      end
      check("full_count", 32'(count), 4);
      check("full_ready", 32'(sec_ready), 0);
      sec_addr = 14; sec_data = 32'hEE;
      step();
      sec_valid = 1'b0;
      check("full_ignore", 32'(count), 4);
      step();
      check("hold_pri_addr3", 32'(addr3), 3);
      pri_wr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("drain_wr", 32'(wr), 1);
         check("drain_addr3", 32'(addr3), 32'(10 + i));
         check("drain_data3", data3, 32'hA0 + i);
         check("drain_count", 32'(count), 32'(3 - i));
      end
      step();
      check("drain_done", 32'(wr), 0);
      // mark and commit of the same register on one edge
      mark_valid = 1'b1; mark_addr = 9; chk_addr2 = 9;
      step();
      mark_valid = 1'b0;
      sec_valid = 1'b1; sec_addr = 9; sec_data = 32'h99;
      step();
      sec_valid = 1'b0;
      wait_wr("t5_wr");
      mark_valid = 1'b1; mark_addr = 9;
      step();
      mark_valid = 1'b0;
      check("set_wins", 32'(busy2), 1);
      // steady push+pop at count=2 across pointer wrap
      pri_wr = 1'b1; pri_addr = 1; pri_data = 0;
      for (int k = 0; k < 2; k++) begin
         sec_valid = 1'b1; sec_addr = AW'(16 + k); sec_data = 32'hC00 + k;
         step();
      end
      pri_wr = 1'b0;
      check("pp_count0", 32'(count), 2);
      for (int k = 2; k < 12; k++) begin
         sec_valid = 1'b1; sec_addr = AW'(16 + k % 8); sec_data = 32'hC00 + k;
         step();
         check("pp_count", 32'(count), 2);
         check("pp_data3", data3, 32'hC00 + k - 2);
      end
      sec_valid = 1'b0;
      for (int k = 10; k < 12; k++) begin
         step();
         check("pp_tail", data3, 32'hC00 + k);
      end
      // reset mid-burst with three queued entries
      pri_wr = 1'b1; pri_addr = 2; pri_data = 32'h22;
      mark_valid = 1'b1; mark_addr = 20; chk_addr1 = 20; chk_addr2 = 21;
      for (int i = 0; i < 3; i++) begin
         sec_valid = 1'b1; sec_addr = AW'(21 + i); sec_data = 32'hB0 + i;
         step();
         mark_valid = 1'b0;
      end
      sec_valid = 1'b0;
      check("pre_rst_count", 32'(count), 3);
      check("pre_rst_busy", 32'(busy1), 1);
      check("pre_rst_wr", 32'(wr), 1);
      reset = 1'b1;
      #1;
      check("mid_rst_wr", 32'(wr), 0);
      check("mid_rst_count", 32'(count), 0);
      check("mid_rst_busy1", 32'(busy1), 0);
      check("mid_rst_busy2", 32'(busy2), 0);
      check("mid_rst_ready", 32'(sec_ready), 0);
      pri_wr = 1'b0;
      step();
      reset = 1'b0;
      #1;
      check("post_rst_ready", 32'(sec_ready), 1);
      step();
      check("post_rst_wr", 32'(wr), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Write-side front end for the 31-entry CPU register file. Merges two result producers onto the register file's single write port (wr/addr3/data3).
  - Primary: the single-cycle ALU/load path, which has priority.
  - Secondary: the long-latency mul/div unit, buffered in a small FIFO.
- Keeps a per-register pending scoreboard so the issue stage can stall on registers still awaiting a long-latency result.

Parameters:
DEPTH, 4, secondary FIFO entries (power of two, >=2)
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
pri_wr  in  1  primary write request (single cycle, no backpressure)
pri_addr  in  AW  primary destination register
pri_data  in  DW  primary write data
sec_valid  in  1  secondary result valid
sec_ready  out  1  FIFO can accept (valid&ready = accepted)
sec_addr  in  AW  secondary destination register
sec_data  in  DW  secondary write data
mark_valid  in  1  issue stage dispatched a long-latency op
mark_addr  in  AW  its destination register
chk_addr1  in  AW  source register 1 to check
chk_addr2  in  AW  source register 2 to check
busy1  out  1  chk_addr1 pending (combinational)
busy2  out  1  chk_addr2 pending (combinational)
wr  out  1  register file write enable (registered)
addr3  out  AW  register file write address (registered)
data3  out  DW  register file write data (registered)
count  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, active-high): wr=0, addr3=0, data3=0, count=0, FIFO empty, pending[31:1]=0, out_sec=0. sec_ready=0 while reset is high. busy1/busy2 follow the cleared scoreboard, so both read 0.
- Output register: loads every edge from the selected source; wr=0 when nothing is selected. Register file commits on the edge after load.
- Selection per edge, in priority order:
  - (a) pri_wr && pri_addr!=0: output gets primary, out_sec=0.
  - (b) else if FIFO non-empty: pop head into output, out_sec=1.
  - (c) else wr=0.
- Primary with pri_addr==0 is dropped (wr stays 0) and does not block the FIFO pop.
- Secondary:
  - Push when sec_valid && sec_ready. sec_ready = !full; no same-cycle credit from a pop.
  - Entries with sec_addr==0 are accepted and discarded: not stored, count unchanged.
  - Pushed entry is eligible for pop from the next edge. Minimum latency is push edge -> pop edge -> wr high for one cycle (2 edges).
- FIFO:
  - Circular pointers wrap modulo DEPTH.
  - Push and pop on the same edge: count unchanged.
  - Full: sec_ready=0, sec_valid ignored.
  - Empty: no pop.
- Scoreboard:
  - mark_valid && mark_addr!=0 sets pending[mark_addr].
  - Cleared on the edge where wr && out_sec (register file commit) for addr3.
  - Set and clear on the same address in the same edge: set wins.
  - busyN = (chk_addrN!=0) && pending[chk_addrN]. busyN drops in the cycle when the register file already holds the data.
- WAW: a primary write to a pending register does not clear pending. The later secondary commit overwrites it. The issue stage must stall on busy to avoid this.
- Reset mid-operation: FIFO contents and pending bits are lost; any in-flight wr is cancelled immediately.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: when the FIFO is empty, primary is not selected, and a non-zero secondary is accepted, the entry goes directly to the output register on the accept edge. It sets out_sec=1 and is never stored, so count stays 0. Latency is 1 edge.
- Not defined: every secondary entry passes through the FIFO (2-edge minimum).

Test Plan:
1. Reset high mid-burst with 3 FIFO entries -> wr=0, count=0, busy1=busy2=0 and sec_ready=0 immediately; sec_ready=1 after release.
2. pri_wr=1, pri_addr=5, pri_data=0x1234 at edge N -> wr=1, addr3=5, data3=0x1234 for one cycle after N. The same request with pri_addr=0 -> wr stays 0.
3. mark r8; push sec (8, 0xDEAD) with no primary traffic -> busy1 (chk_addr1=8) high until the commit edge, then low. wr=1/addr3=8 exactly 2 edges after push, or 1 edge with WB_BYPASS_EN.
4. Push 4 secondary entries while pri_wr held high 6 cycles -> sec_ready=0 at count=4. Entries drain in FIFO order only after pri_wr drops, one per cycle.
5. Same edge: mark r9 and commit of r9 -> pending[9] stays set (busy for chk_addr=9 remains 1).
6. Push and pop on the same edge at count=2 -> count stays 2. Pointer wrap after 2*DEPTH transfers preserves data order.
